regfile_sb: RTL and testbench

- Parametrised successor to the core's integer register file: configurable word width, register count and read-port count.
- Adds a pending-write scoreboard (busy bit per register) for multi-cycle producers such as loads and the divider.
- Adds a reset-time sweep FSM that clears every register after reset.
- Sits between decode (reads, reserves) and writeback (writes, which release reservations).

---
 rtl/regfile_sb.sv | 174 +++++++++++++++++
 tb/tb_regfile_sb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a pending-write
// scoreboard (one busy bit per register) and a post-reset clearing sweep.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read port whose address matches an accepted write in the
//                same cycle returns the write data combinationally.
//   undefined -> reads always return the stored (pre-edge) value and busy bit.
//
// Handshake: there is no valid/ready pair on the datapath. o_ready is a level
// that rises once the clearing sweep has finished. i_write and i_reserve are
// single-cycle strobes that take effect on the rising edge only while o_ready
// is high; while o_ready is low they are silently dropped.
//
// FSM state is held in r_state (ST_INIT / ST_RUN). o_ready is its direct
// decode, so the state is visible at the port boundary.

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NRD*$clog2(NREGS)-1:0] i_raddr,
    output logic [NRD*XLEN-1:0]         o_rdata,
    output logic [NRD-1:0]              o_rbusy,
    input  logic                        i_write,
    input  logic [$clog2(NREGS)-1:0]    i_waddr,
    input  logic [XLEN-1:0]             i_wdata,
    input  logic                        i_reserve,
    input  logic [$clog2(NREGS)-1:0]    i_rsv_addr,
    output logic                        o_ready
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int AW = $clog2(NREGS);

    // Register 0 hardwired to zero when set.
    localparam bit ZR = (ZERO_REG != 0);

    // The sweep skips register 0 when it is hardwired, so it starts at 1.
    localparam logic [AW-1:0] CNT_START = ZR ? AW'(1) : '0;
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREGS - 1);

    // FSM encoding
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [AW-1:0]   r_cnt;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    // ------------------------------------------------------------------
    // Qualified write / reserve strobes
    // ------------------------------------------------------------------
    logic w_ready;
    logic w_wr_en;
    logic w_rsv_en;
    logic w_wr_is_zero;
    logic w_rsv_is_zero;

    assign w_ready       = (r_state == ST_RUN);
    assign w_wr_is_zero  = ZR && (i_waddr == '0);
    assign w_rsv_is_zero = ZR && (i_rsv_addr == '0);

    // Writes and reserves are accepted only after the sweep, and never
    // touch a hardwired register 0.
    assign w_wr_en  = i_write   && w_ready && !w_wr_is_zero;
    assign w_rsv_en = i_reserve && w_ready && !w_rsv_is_zero;

    assign o_ready = w_ready;

    // ------------------------------------------------------------------
    // Sweep FSM: reset enters INIT, the counter walks every register once,
    // and the last register cleared moves the block into RUN for good.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_INIT;
            r_cnt   <= CNT_START;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= CNT_START;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register array: cleared by the sweep, then written by writeback.
    // Reset itself does not clear the array; the sweep that follows does.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == ST_INIT) begin
                r_regs[r_cnt] <= '0;
            end else if (w_wr_en) begin
                r_regs[i_waddr] <= i_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: a write releases its register, a reserve marks it busy.
    // The reserve is applied last so that, on the same address, the
    // younger instruction's reservation survives the older one's write.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_busy[i_waddr] <= 1'b0;
            end
            if (w_rsv_en) begin
                r_busy[i_rsv_addr] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports: fully combinational, one independent mux per port.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        logic            w_rb;

        assign w_ra = i_raddr[g*AW +: AW];

        // Select stored data/busy, optionally forward a same-cycle write,
        // then force zero for hardwired reg0 and while the sweep runs.
        always_comb begin
            w_rd = r_regs[w_ra];
            w_rb = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en && (w_ra == i_waddr)) begin
                w_rd = i_wdata;
                w_rb = w_rsv_en && (i_rsv_addr == w_ra);
            end
`endif
            if (ZR && (w_ra == '0)) begin
                w_rd = '0;
                w_rb = 1'b0;
            end
            if (!w_ready) begin
                w_rd = '0;
                w_rb = 1'b0;
            end
        end

        assign o_rdata[g*XLEN +: XLEN] = w_rd;
        assign o_rbusy[g]              = w_rb;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb. Instance A uses the default
// parameters (32x32, 2 ports, reg0 hardwired); instance B uses 64-bit words,
// 16 registers, 3 ports and an ordinary reg0.

module tb_regfile_sb;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        rst_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic [1:0]  rbusy_a;
    logic        write_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic        reserve_a;
    logic [4:0]  rsv_addr_a;
    logic        ready_a;

    // Instance B signals
    logic         rst_b;
    logic [11:0]  raddr_b;
    logic [191:0] rdata_b;
    logic [2:0]   rbusy_b;
    logic         write_b;
    logic [3:0]   waddr_b;
    logic [63:0]  wdata_b;
    logic         reserve_b;
    logic [3:0]   rsv_addr_b;
    logic         ready_b;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) u_dut_a (
        .i_clk      (clk),
        .i_rst      (rst_a),
        .i_raddr    (raddr_a),
        .o_rdata    (rdata_a),
        .o_rbusy    (rbusy_a),
        .i_write    (write_a),
        .i_waddr    (waddr_a),
        .i_wdata    (wdata_a),
        .i_reserve  (reserve_a),
        .i_rsv_addr (rsv_addr_a),
        .o_ready    (ready_a)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_dut_b (
        .i_clk      (clk),
        .i_rst      (rst_b),
        .i_raddr    (raddr_b),
        .o_rdata    (rdata_b),
        .o_rbusy    (rbusy_b),
        .i_write    (write_b),
        .i_waddr    (waddr_b),
        .i_wdata    (wdata_b),
        .i_reserve  (reserve_b),
        .i_rsv_addr (rsv_addr_b),
        .o_ready    (ready_b)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        write_a   = 1'b0;
        reserve_a = 1'b0;
        waddr_a   = '0;
        wdata_a   = '0;
        rsv_addr_a = '0;
    endtask

    task automatic idle_b();
        write_b   = 1'b0;
        reserve_b = 1'b0;
        waddr_b   = '0;
        wdata_b   = '0;
        rsv_addr_b = '0;
    endtask

    task automatic rd_a(input logic [4:0] p0, input logic [4:0] p1);
        raddr_a = {p1, p0};
        #1;
    endtask

    // Count edges after reset release until o_ready rises (bounded).
    task automatic wait_ready_a(output int n);
        n = 0;
        while (!ready_a && n < 100) begin
            step();
            n++;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        raddr_a = '0;
        raddr_b = '0;
        idle_a();
        idle_b();

        // ---- Init sweep on A, with write/reserve of x3 at sweep cycle 10
        step();
        check("a_ready_in_reset", {63'd0, ready_a}, 64'd0);
        rst_a = 1'b0;
        rd_a(5'd5, 5'd3);
        n = 0;
        while (!ready_a && n < 100) begin
            if (n == 4) begin
                check("a_init_rdata_zero", rdata_a, 64'd0);
                check("a_init_rbusy_zero", {62'd0, rbusy_a}, 64'd0);
            end
            if (n == 9) begin
                write_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hFF;
                reserve_a = 1'b1; rsv_addr_a = 5'd3;
            end else begin
                idle_a();
            end
            step();
            n++;
        end
        idle_a();
        check("a_sweep_len", 64'(n), 64'd31);
        check("a_ready_after_sweep", {63'd0, ready_a}, 64'd1);

        // ---- Every register reads 0 / not busy on both ports
        for (int i = 0; i < 32; i++) begin
            rd_a(5'(i), 5'(31 - i));
            check("a_swept_rdata", rdata_a, 64'd0);
            check("a_swept_rbusy", {62'd0, rbusy_a}, 64'd0);
        end
        rd_a(5'd3, 5'd3);
        check("a_x3_ignored_data", {32'd0, rdata_a[31:0]}, 64'd0);
        check("a_x3_ignored_busy", {63'd0, rbusy_a[0]}, 64'd0);

        // ---- Basic write / read
        write_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF;
        step();
        idle_a();
        rd_a(5'd5, 5'd5);
        check("a_x5_p0", {32'd0, rdata_a[31:0]}, 64'hDEADBEEF);
        check("a_x5_p1_same", {32'd0, rdata_a[63:32]}, 64'hDEADBEEF);

        write_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h1234;
        step();
        idle_a();
        rd_a(5'd0, 5'd0);
        check("a_x0_hardwired", rdata_a, 64'd0);

        // ---- Scoreboard
        reserve_a = 1'b1; rsv_addr_a = 5'd7;
        step();
        idle_a();
        rd_a(5'd7, 5'd0);
        check("a_x7_reserved_busy", {62'd0, rbusy_a}, 64'd1);

        write_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h42;
        step();
        idle_a();
        rd_a(5'd7, 5'd0);
        check("a_x7_written_busy", {62'd0, rbusy_a}, 64'd0);
        check("a_x7_written_data", {32'd0, rdata_a[31:0]}, 64'h42);

        write_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h42;
        reserve_a = 1'b1; rsv_addr_a = 5'd7;
        step();
        idle_a();
        rd_a(5'd7, 5'd0);
        check("a_x7_wr_rsv_data", {32'd0, rdata_a[31:0]}, 64'h42);
        check("a_x7_wr_rsv_busy", {62'd0, rbusy_a}, 64'd1);

        // Write x10 and reserve x11 in the same cycle
        write_a = 1'b1; waddr_a = 5'd10; wdata_a = 32'h111;
        reserve_a = 1'b1; rsv_addr_a = 5'd11;
        step();
        idle_a();
        rd_a(5'd10, 5'd11);
        check("a_x10_data", {32'd0, rdata_a[31:0]}, 64'h111);
        check("a_x10_x11_busy", {62'd0, rbusy_a}, 64'd2);

        // Reserving reg0 is a no-op
        reserve_a = 1'b1; rsv_addr_a = 5'd0;
        step();
        idle_a();
        rd_a(5'd0, 5'd12);
        check("a_x0_never_busy", {63'd0, rbusy_a[0]}, 64'd0);

        // ---- Bypass x9 on port 1
        rd_a(5'd0, 5'd9);
        write_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("a_x9_same_cycle", {32'd0, rdata_a[63:32]}, 64'hA5A5A5A5);
`else
        check("a_x9_same_cycle", {32'd0, rdata_a[63:32]}, 64'd0);
`endif
        check("a_x9_same_cycle_busy", {63'd0, rbusy_a[1]}, 64'd0);
        step();
        idle_a();
        #1;
        check("a_x9_next_cycle", {32'd0, rdata_a[63:32]}, 64'hA5A5A5A5);

        // Bypass with a same-address reserve, and reg0 never forwarded
        rd_a(5'd13, 5'd0);
        write_a = 1'b1; waddr_a = 5'd13; wdata_a = 32'h77;
        reserve_a = 1'b1; rsv_addr_a = 5'd13;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("a_x13_same_cycle_data", {32'd0, rdata_a[31:0]}, 64'h77);
        check("a_x13_same_cycle_busy", {63'd0, rbusy_a[0]}, 64'd1);
`else
        check("a_x13_same_cycle_data", {32'd0, rdata_a[31:0]}, 64'd0);
        check("a_x13_same_cycle_busy", {63'd0, rbusy_a[0]}, 64'd0);
`endif
        step();
        idle_a();
        #1;
        check("a_x13_after_data", {32'd0, rdata_a[31:0]}, 64'h77);
        check("a_x13_after_busy", {63'd0, rbusy_a[0]}, 64'd1);

        write_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hCAFE;
        rd_a(5'd0, 5'd0);
        check("a_x0_no_bypass", rdata_a, 64'd0);
        step();
        idle_a();

        // ---- Reset mid-operation, then reset again mid-sweep
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("a_ready_mid_sweep", {63'd0, ready_a}, 64'd0);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        wait_ready_a(n);
        check("a_resweep_len", 64'(n), 64'd31);
        rd_a(5'd7, 5'd13);
        check("a_busy_cleared_by_reset", {62'd0, rbusy_a}, 64'd0);
        check("a_data_cleared_by_sweep", rdata_a, 64'd0);

        // ---- Instance B: 64-bit, 16 regs, 3 ports, ordinary reg0
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        n = 0;
        while (!ready_b && n < 100) begin
            step();
            n++;
        end
        check("b_sweep_len", 64'(n), 64'd16);

        write_b = 1'b1; waddr_b = 4'd0; wdata_b = 64'h1;
        step();
        write_b = 1'b1; waddr_b = 4'd3; wdata_b = 64'h0123456789ABCDEF;
        step();
        write_b = 1'b1; waddr_b = 4'd15; wdata_b = 64'hFEDCBA9876543210;
        reserve_b = 1'b1; rsv_addr_b = 4'd0;
        step();
        idle_b();
        raddr_b = {4'd15, 4'd3, 4'd0};
        #1;
        check("b_p0_reg0", rdata_b[63:0], 64'h1);
        check("b_p1_reg3", rdata_b[127:64], 64'h0123456789ABCDEF);
        check("b_p2_reg15", rdata_b[191:128], 64'hFEDCBA9876543210);
        check("b_reg0_busy", {61'd0, rbusy_b}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
